wb_timeout_interconnect: RTL and testbench
==========================================

WB_TIMEOUT_INTERCONNECT -- requirements
Module: wb_timeout_interconnect

Interface
REQ-001 Parameter NUM_TEAMS, default 12: number of team designs; the design index range is 1..NUM_TEAMS.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: the maximum number of cycles in ACTIVE before a forced response; the legal range is 2..65535.
REQ-003 Parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on timeout or on an unmapped access.
REQ-004 wb_clk_i  in  1  single clock; every register is clocked on its rising edge.
REQ-005 wb_rst_i  in  1  reset, asynchronous and active-high.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  master cycle, strobe and write enable.
REQ-007 wbs_adr_i, wbs_dat_i  in  32 each  master address and write data.
REQ-008 wbs_ack_o  out  1  acknowledge to the master; wbs_dat_o  out  32  read data to the master.
REQ-009 designs_stb  out  NUM_TEAMS+1  per-design strobe; la_control_stb and gpio_control_stb  out  1 each.
REQ-010 adr_truncated  out  32  {16'b0, latched address[15:0]}.
REQ-011 slave_we_o  out  1  and  slave_dat_o  out  32: latched write enable and write data to the slaves.
REQ-012 designs_wbs_dat_o_flat  in  32*(NUM_TEAMS+1)  design read data, with design i in bits [i*32 +: 32].
REQ-013 la_control_dat_o and gpio_control_dat_o  in  32 each; designs_ack_o  in  NUM_TEAMS+1; la_control_ack_o and gpio_control_ack_o  in  1 each.
REQ-014 timeout_irq  out  1  sticky error flag.

Function
REQ-015 Decode: address 0x30NN_xxxx with 1<=NN<=NUM_TEAMS SHALL select design NN; 0x3100_xxxx SHALL select LA; 0x3200_xxxx SHALL select GPIO; 0x3300_xxxx SHALL select the internal STATUS register; every other address, including NN=0, SHALL be unmapped.
REQ-016 The FSM SHALL have three states (IDLE, ACTIVE, RESP) and SHALL reset to IDLE.
REQ-017 In IDLE with wbs_cyc_i&wbs_stb_i high, the block SHALL latch the address, wbs_we_i, wbs_dat_i and the decoded target, then:
- go to ACTIVE for LA, GPIO or a design;
- go to RESP for STATUS or unmapped.
REQ-018 In ACTIVE, exactly one slave strobe SHALL be high (the latched target); all other strobes SHALL be 0; designs_stb[0] SHALL always be 0.
REQ-019 ACTIVE with the selected slave ack high SHALL capture that slave's dat_o and go to RESP.
REQ-020 Timeout counter:
- cleared on entry to ACTIVE;
- increments once per ACTIVE cycle with no ack;
- when it equals TIMEOUT_CYCLES-1 with no ack, the FSM SHALL capture ERR_DATA, set the sticky bit, record the target and go to RESP.
REQ-021 Ack and timeout in the same cycle: the ack SHALL win, and the slave data SHALL be returned with no error recorded.
REQ-022 RESP SHALL assert wbs_ack_o for exactly one cycle with the captured wbs_dat_o, then go to IDLE; wbs_dat_o SHALL be 0 whenever wbs_ack_o is 0.
REQ-023 Unmapped access: it SHALL return ERR_DATA and set the sticky bit, without incrementing the count.
REQ-024 STATUS read data SHALL be {15'b0, sticky, last_target[7:0], timeout_count[7:0]}:
- timeout_count saturates at 255;
- last_target is the design index, 0xFD for LA, 0xFE for GPIO, 0xFF for unmapped.
REQ-025 A STATUS write SHALL clear the count, last_target and sticky bit in the RESP cycle and SHALL return 0 data.
REQ-026 wbs_cyc_i low in ACTIVE SHALL abort the access: return to IDLE next cycle, all strobes 0, no ack, no status update.
REQ-027 timeout_irq SHALL equal the sticky bit.
REQ-028 Latency: a slave acking in its first strobe cycle SHALL produce wbs_ack_o 2 cycles after the master strobe; STATUS and unmapped accesses SHALL produce it after 1 cycle.

Reset
REQ-029 wb_rst_i high SHALL immediately force IDLE and clear the following: all strobes, wbs_ack_o, wbs_dat_o, slave_we_o, slave_dat_o, adr_truncated, the counter, STATUS fields and timeout_irq.
REQ-030 A reset during ACTIVE or RESP SHALL drop the in-flight access with no ack after reset release.

Verification
REQ-031 Read 0x3003_0010 with design 3 acking 1 cycle after strobe with 0x1234_5678 -> designs_stb[3] high, adr_truncated=0x10, wbs_ack_o high for one cycle with 0x1234_5678.
REQ-032 Read GPIO with no ack, TIMEOUT_CYCLES=4 -> gpio_control_stb high for 4 cycles, ack with 0xDEAD_BEEF, timeout_irq=1, STATUS=0x0001_FE01.
REQ-033 Read 0x3000_0000 and 0x3400_0000 -> no slave strobe, ack after 1 cycle with 0xDEAD_BEEF each, count unchanged.
REQ-034 Write 0x3300_0000 after REQ-032 -> ack, timeout_irq=0, STATUS reads 0.
REQ-035 Ack arrives on cycle TIMEOUT_CYCLES-1 -> slave data returned, timeout_irq stays 0; drop wbs_cyc_i mid-ACTIVE -> no ack, IDLE next cycle.
REQ-036 Assert wb_rst_i mid-ACTIVE -> all outputs 0 asynchronously; a fresh read afterwards completes normally.

Source files
------------

// File: rtl/wb_timeout_interconnect.sv
// Wishbone interconnect: decodes master accesses onto team designs, LA and GPIO, and holds a STATUS register.
// Any slave access that outlasts TIMEOUT_CYCLES is answered with ERR_DATA and recorded in STATUS.
module wb_timeout_interconnect #(
  parameter int          NUM_TEAMS      = 12,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_we_i,
  input  logic [31:0]                  wbs_adr_i,
  input  logic [31:0]                  wbs_dat_i,
  output logic                         wbs_ack_o,
  output logic [31:0]                  wbs_dat_o,
  output logic [NUM_TEAMS:0]           designs_stb,
  output logic                         la_control_stb,
  output logic                         gpio_control_stb,
  output logic [31:0]                  adr_truncated,
  output logic                         slave_we_o,
  output logic [31:0]                  slave_dat_o,
  input  logic [32*(NUM_TEAMS+1)-1:0]  designs_wbs_dat_o_flat,
  input  logic [31:0]                  la_control_dat_o,
  input  logic [31:0]                  gpio_control_dat_o,
  input  logic [NUM_TEAMS:0]           designs_ack_o,
  input  logic                         la_control_ack_o,
  input  logic                         gpio_control_ack_o,
  output logic                         timeout_irq
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [2:0] SEL_DESIGN = 3'd0;
  localparam logic [2:0] SEL_LA     = 3'd1;
  localparam logic [2:0] SEL_GPIO   = 3'd2;
  localparam logic [2:0] SEL_STATUS = 3'd3;
  localparam logic [2:0] SEL_UNMAP  = 3'd4;

  localparam logic [7:0] TGT_LA    = 8'hFD;
  localparam logic [7:0] TGT_GPIO  = 8'hFE;
  localparam logic [7:0] TGT_UNMAP = 8'hFF;

  logic [1:0]  state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [7:0]  tgt_q, tgt_d;
  logic [15:0] adr_q, adr_d;
  logic        we_q, we_d;
  logic [31:0] dat_q, dat_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] resp_q, resp_d;
  logic        sticky_q, sticky_d;
  logic [7:0]  last_q, last_d;
  logic [7:0]  tcount_q, tcount_d;

  logic [2:0]  dec_sel;
  logic [7:0]  dec_tgt;
  logic        sel_ack;
  logic [31:0] sel_dat;
  logic        active;
  logic [31:0] status_word;

  // Design 0 does not exist; its ack and data lanes are never looked at.
  logic unused_design0;
  assign unused_design0 = ^{designs_ack_o[0], designs_wbs_dat_o_flat[31:0]};

  always_comb begin
    dec_sel = SEL_UNMAP;
    dec_tgt = TGT_UNMAP;
    if (wbs_adr_i[31:24] == 8'h30 && wbs_adr_i[23:16] != 8'h00 &&
        {24'b0, wbs_adr_i[23:16]} <= 32'(NUM_TEAMS)) begin
      dec_sel = SEL_DESIGN;
      dec_tgt = wbs_adr_i[23:16];
    end else begin
      case (wbs_adr_i[31:16])
        16'h3100: begin dec_sel = SEL_LA;     dec_tgt = TGT_LA;    end
        16'h3200: begin dec_sel = SEL_GPIO;   dec_tgt = TGT_GPIO;  end
        16'h3300: begin dec_sel = SEL_STATUS; dec_tgt = TGT_UNMAP; end
        default:  ;
      endcase
    end
  end

  // Strobes follow cyc so an abort takes the slave off the bus in the same cycle.
  assign active = (state_q == ST_ACTIVE) && wbs_cyc_i;

  always_comb begin
    sel_ack          = 1'b0;
    sel_dat          = 32'h0;
    designs_stb      = '0;
    la_control_stb   = 1'b0;
    gpio_control_stb = 1'b0;
    case (sel_q)
      SEL_LA: begin
        sel_ack        = la_control_ack_o;
        sel_dat        = la_control_dat_o;
        la_control_stb = active;
      end
      SEL_GPIO: begin
        sel_ack          = gpio_control_ack_o;
        sel_dat          = gpio_control_dat_o;
        gpio_control_stb = active;
      end
      SEL_DESIGN: begin
        for (int i = 1; i <= NUM_TEAMS; i++) begin
          if (tgt_q == 8'(i)) begin
            sel_ack        = designs_ack_o[i];
            sel_dat        = designs_wbs_dat_o_flat[i*32 +: 32];
            designs_stb[i] = active;
          end
        end
      end
      default: ;
    endcase
  end

  assign status_word = {15'b0, sticky_q, last_q, tcount_q};

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    tgt_d    = tgt_q;
    adr_d    = adr_q;
    we_d     = we_q;
    dat_d    = dat_q;
    cnt_d    = cnt_q;
    resp_d   = resp_q;
    sticky_d = sticky_q;
    last_d   = last_q;
    tcount_d = tcount_q;
    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          sel_d = dec_sel;
          tgt_d = dec_tgt;
          adr_d = wbs_adr_i[15:0];
          we_d  = wbs_we_i;
          dat_d = wbs_dat_i;
          cnt_d = 16'h0;
          case (dec_sel)
            SEL_STATUS: begin
              state_d = ST_RESP;
              if (wbs_we_i) begin
                resp_d   = 32'h0;
                sticky_d = 1'b0;
                last_d   = 8'h00;
                tcount_d = 8'h00;
              end else begin
                resp_d = status_word;
              end
            end
            SEL_UNMAP: begin
              state_d  = ST_RESP;
              resp_d   = ERR_DATA;
              sticky_d = 1'b1;
              last_d   = TGT_UNMAP;
            end
            default: state_d = ST_ACTIVE;
          endcase
        end
      end
      ST_ACTIVE: begin
        // Abort beats ack, and ack beats timeout.
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (sel_ack) begin
          resp_d  = sel_dat;
          state_d = ST_RESP;
        end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          resp_d   = ERR_DATA;
          sticky_d = 1'b1;
          last_d   = tgt_q;
          if (tcount_q != 8'hFF) tcount_d = tcount_q + 8'd1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      sel_q    <= SEL_UNMAP;
      tgt_q    <= 8'h00;
      adr_q    <= 16'h0;
      we_q     <= 1'b0;
      dat_q    <= 32'h0;
      cnt_q    <= 16'h0;
      resp_q   <= 32'h0;
      sticky_q <= 1'b0;
      last_q   <= 8'h00;
      tcount_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      tgt_q    <= tgt_d;
      adr_q    <= adr_d;
      we_q     <= we_d;
      dat_q    <= dat_d;
      cnt_q    <= cnt_d;
      resp_q   <= resp_d;
      sticky_q <= sticky_d;
      last_q   <= last_d;
      tcount_q <= tcount_d;
    end
  end

  assign wbs_ack_o     = (state_q == ST_RESP);
  assign wbs_dat_o     = (state_q == ST_RESP) ? resp_q : 32'h0;
  assign adr_truncated = {16'b0, adr_q};
  assign slave_we_o    = we_q;
  assign slave_dat_o   = dat_q;
  assign timeout_irq   = sticky_q;

endmodule

// File: tb/tb_wb_timeout_interconnect.sv
// Randomized bench for wb_timeout_interconnect: a transaction-level model predicts every output
// cycle by cycle from the access kind, slave ack delay and abort point.
module tb_wb_timeout_interconnect;

  localparam int          NT  = 12;
  localparam int          T   = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  localparam int K_DES   = 0;
  localparam int K_LA    = 1;
  localparam int K_GPIO  = 2;
  localparam int K_STAT  = 3;
  localparam int K_UNMAP = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cyc, stb, we;
  logic [31:0]          adr, dat;
  logic                 wbsAck;
  logic [31:0]          wbsDat;
  logic [NT:0]          desStb;
  logic                 laStb, gpioStb;
  logic [31:0]          adrTrunc;
  logic                 slvWe;
  logic [31:0]          slvDat;
  logic [32*(NT+1)-1:0] desDat;
  logic [31:0]          laDat, gpioDat;
  logic [NT:0]          desAck;
  logic                 laAck, gpioAck;
  logic                 irq;

  always #5 clk = ~clk;

  wb_timeout_interconnect #(
    .NUM_TEAMS(NT), .TIMEOUT_CYCLES(T), .ERR_DATA(ERR)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(dat),
    .wbs_ack_o(wbsAck), .wbs_dat_o(wbsDat),
    .designs_stb(desStb), .la_control_stb(laStb), .gpio_control_stb(gpioStb),
    .adr_truncated(adrTrunc), .slave_we_o(slvWe), .slave_dat_o(slvDat),
    .designs_wbs_dat_o_flat(desDat),
    .la_control_dat_o(laDat), .gpio_control_dat_o(gpioDat),
    .designs_ack_o(desAck), .la_control_ack_o(laAck), .gpio_control_ack_o(gpioAck),
    .timeout_irq(irq)
  );

  int asserts  = 0;
  int failures = 0;
  int ackCount = 0;
  int stbCycles = 0;
  logic [31:0] capturedDat = 32'h0;
  logic checkEn = 1'b0;

  logic [NT:0] expDesStb;
  logic        expLa, expGpio, expAck, expIrq, expWe;
  logic [31:0] expDat, expAdr, expWdat;

  // Abstract STATUS and latch model
  logic        mSticky;
  logic [7:0]  mLast, mCnt;
  logic [15:0] mAdr;
  logic        mWe;
  logic [31:0] mWdat;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check32("wbs_ack_o", 32'(wbsAck), 32'(expAck));
    check32("wbs_dat_o", wbsDat, expDat);
    check32("designs_stb", 32'(desStb), 32'(expDesStb));
    check32("la_control_stb", 32'(laStb), 32'(expLa));
    check32("gpio_control_stb", 32'(gpioStb), 32'(expGpio));
    check32("adr_truncated", adrTrunc, expAdr);
    check32("slave_we_o", 32'(slvWe), 32'(expWe));
    check32("slave_dat_o", slvDat, expWdat);
    check32("timeout_irq", 32'(irq), 32'(expIrq));
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput();
      if (wbsAck === 1'b1) begin
        ackCount++;
        capturedDat = wbsDat;
      end
      if ((|desStb) || laStb || gpioStb) stbCycles++;
    end
  end

  function automatic void classify(input logic [31:0] a, output int kind, output int tgt);
    kind = K_UNMAP;
    tgt  = 255;
    if (a[31:24] == 8'h30 && a[23:16] != 8'h00 && int'(a[23:16]) <= NT) begin
      kind = K_DES;
      tgt  = int'(a[23:16]);
    end else if (a[31:16] == 16'h3100) begin
      kind = K_LA;   tgt = 253;
    end else if (a[31:16] == 16'h3200) begin
      kind = K_GPIO; tgt = 254;
    end else if (a[31:16] == 16'h3300) begin
      kind = K_STAT; tgt = 0;
    end
  endfunction

  // Unselected slaves ack at random; the selected one acks only as told.
  task automatic driveAcks(input int kind, input int tgt, input logic selAck);
    for (int i = 0; i <= NT; i++) desAck[i] = 1'($urandom_range(0, 1));
    laAck   = 1'($urandom_range(0, 1));
    gpioAck = 1'($urandom_range(0, 1));
    case (kind)
      K_DES:   desAck[tgt] = selAck;
      K_LA:    laAck = selAck;
      K_GPIO:  gpioAck = selAck;
      default: ;
    endcase
  endtask

  task automatic setExp(input logic strobeOn, input int kind, input int tgt,
                        input logic ack, input logic [31:0] data);
    expDesStb = '0;
    expLa     = 1'b0;
    expGpio   = 1'b0;
    if (strobeOn) begin
      case (kind)
        K_DES:   expDesStb[tgt] = 1'b1;
        K_LA:    expLa = 1'b1;
        K_GPIO:  expGpio = 1'b1;
        default: ;
      endcase
    end
    expAck  = ack;
    expDat  = data;
    expIrq  = mSticky;
    expAdr  = {16'b0, mAdr};
    expWe   = mWe;
    expWdat = mWdat;
  endtask

  task automatic idleCycles(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      driveAcks(K_UNMAP, 0, 1'b0);
      setExp(1'b0, K_UNMAP, 0, 1'b0, 32'h0);
    end
  endtask

  // One master access; ackDelay is the strobe cycle (0-based) the slave acks on, -1 never;
  // abortAt>0 drops cyc in that strobe cycle (1-based).
  task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [31:0] d,
                               input logic [31:0] slvData, input int ackDelay, input int abortAt);
    int kind, tgt, nAct;
    logic timedOut;
    logic [31:0] rdata;
    classify(a, kind, tgt);
    for (int i = 0; i <= NT; i++) desDat[i*32 +: 32] = $urandom;
    laDat   = $urandom;
    gpioDat = $urandom;
    case (kind)
      K_DES:   desDat[tgt*32 +: 32] = slvData;
      K_LA:    laDat = slvData;
      K_GPIO:  gpioDat = slvData;
      default: ;
    endcase

    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; dat = d;
    driveAcks(kind, tgt, 1'($urandom_range(0, 1)));
    setExp(1'b0, kind, tgt, 1'b0, 32'h0);

    @(posedge clk); #1;
    mAdr = a[15:0]; mWe = w; mWdat = d;
    if (kind == K_STAT || kind == K_UNMAP) begin
      if (kind == K_UNMAP) begin
        rdata = ERR; mSticky = 1'b1; mLast = 8'hFF;
      end else if (w) begin
        rdata = 32'h0; mSticky = 1'b0; mLast = 8'h00; mCnt = 8'h00;
      end else begin
        rdata = {15'b0, mSticky, mLast, mCnt};
      end
      driveAcks(kind, tgt, 1'($urandom_range(0, 1)));
      setExp(1'b0, kind, tgt, 1'b1, rdata);
      idleCycles(1);
    end else if (abortAt > 0) begin
      for (int j = 1; j <= abortAt; j++) begin
        if (j > 1) begin @(posedge clk); #1; end
        driveAcks(kind, tgt, 1'b0);
        if (j == abortAt) begin
          cyc = 1'b0; stb = 1'b0;
          setExp(1'b0, kind, tgt, 1'b0, 32'h0);
        end else begin
          setExp(1'b1, kind, tgt, 1'b0, 32'h0);
        end
      end
      idleCycles(T + 2);
    end else begin
      timedOut = (ackDelay < 0 || ackDelay > T - 1);
      nAct = timedOut ? T : ackDelay + 1;
      for (int j = 1; j <= nAct; j++) begin
        if (j > 1) begin @(posedge clk); #1; end
        driveAcks(kind, tgt, (!timedOut && (j - 1 == ackDelay)));
        setExp(1'b1, kind, tgt, 1'b0, 32'h0);
      end
      @(posedge clk); #1;
      if (timedOut) begin
        rdata = ERR; mSticky = 1'b1; mLast = 8'(tgt);
        if (mCnt != 8'hFF) mCnt = mCnt + 8'd1;
      end else begin
        rdata = slvData;
      end
      driveAcks(kind, tgt, 1'($urandom_range(0, 1)));
      setExp(1'b0, kind, tgt, 1'b1, rdata);
      idleCycles(1);
    end
  endtask

  task automatic resetMidActive();
    int n;
    applyStimulus(32'h3400_1234, 1'b0, 32'h0, 32'h0, -1, 0);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = 32'h3009_BEEF; we = 1'b1; dat = 32'h1357_9BDF;
    driveAcks(K_DES, 9, 1'b0);
    setExp(1'b0, K_DES, 9, 1'b0, 32'h0);
    @(posedge clk); #1;
    mAdr = 16'hBEEF; mWe = 1'b1; mWdat = 32'h1357_9BDF;
    driveAcks(K_DES, 9, 1'b0);
    setExp(1'b1, K_DES, 9, 1'b0, 32'h0);
    @(posedge clk); #3;
    checkEn = 1'b0;
    rst = 1'b1;
    #1;
    check32("rst ack", 32'(wbsAck), 32'h0);
    check32("rst dat", wbsDat, 32'h0);
    check32("rst designs_stb", 32'(desStb), 32'h0);
    check32("rst la/gpio stb", {30'b0, laStb, gpioStb}, 32'h0);
    check32("rst adr_truncated", adrTrunc, 32'h0);
    check32("rst slave_we", 32'(slvWe), 32'h0);
    check32("rst slave_dat", slvDat, 32'h0);
    check32("rst irq", 32'(irq), 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    mSticky = 1'b0; mLast = 8'h00; mCnt = 8'h00; mAdr = 16'h0; mWe = 1'b0; mWdat = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    setExp(1'b0, K_UNMAP, 0, 1'b0, 32'h0);
    checkEn = 1'b1;
    n = ackCount;
    idleCycles(T + 2);
    check32("no ack after reset", 32'(ackCount), 32'(n));
    applyStimulus(32'h3009_0000, 1'b0, 32'h0, 32'h0BAD_F00D, 0, 0);
    check32("read after reset", capturedDat, 32'h0BAD_F00D);
  endtask

  initial begin
    int n;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h0; dat = 32'h0;
    desAck = '0; laAck = 1'b0; gpioAck = 1'b0;
    desDat = '0; laDat = 32'h0; gpioDat = 32'h0;
    #1 rst = 1'b1;
    #2;
    check32("reset ack", 32'(wbsAck), 32'h0);
    check32("reset irq", 32'(irq), 32'h0);
    check32("reset designs_stb", 32'(desStb), 32'h0);
    mSticky = 1'b0; mLast = 8'h00; mCnt = 8'h00; mAdr = 16'h0; mWe = 1'b0; mWdat = 32'h0;
    setExp(1'b0, K_UNMAP, 0, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkEn = 1'b1;
    idleCycles(2);

    $display("[TB] directed accesses");
    stbCycles = 0;
    applyStimulus(32'h3003_0010, 1'b0, 32'h0, 32'h1234_5678, 1, 0);
    check32("design3 read data", capturedDat, 32'h1234_5678);
    check32("design3 adr_truncated", adrTrunc, 32'h0000_0010);
    check32("design3 strobe cycles", 32'(stbCycles), 32'd2);

    stbCycles = 0;
    applyStimulus(32'h3200_0000, 1'b0, 32'h0, 32'h5555_AAAA, -1, 0);
    check32("gpio strobe cycles", 32'(stbCycles), 32'd4);
    check32("gpio timeout data", capturedDat, 32'hDEAD_BEEF);
    check32("gpio timeout irq", 32'(irq), 32'h1);
    applyStimulus(32'h3300_0000, 1'b0, 32'h0, 32'h0, -1, 0);
    check32("status after gpio timeout", capturedDat, 32'h0001_FE01);

    stbCycles = 0;
    applyStimulus(32'h3000_0000, 1'b0, 32'h0, 32'h0, -1, 0);
    check32("design0 unmapped data", capturedDat, 32'hDEAD_BEEF);
    applyStimulus(32'h3400_0000, 1'b0, 32'h0, 32'h0, -1, 0);
    check32("0x34 unmapped data", capturedDat, 32'hDEAD_BEEF);
    check32("unmapped strobe cycles", 32'(stbCycles), 32'd0);
    applyStimulus(32'h3300_0000, 1'b0, 32'h0, 32'h0, -1, 0);
    check32("status after unmapped", capturedDat, 32'h0001_FF01);

    applyStimulus(32'h3300_0000, 1'b1, 32'hFFFF_FFFF, 32'h0, -1, 0);
    check32("status write data", capturedDat, 32'h0);
    check32("status write irq", 32'(irq), 32'h0);
    applyStimulus(32'h3300_0000, 1'b0, 32'h0, 32'h0, -1, 0);
    check32("status after clear", capturedDat, 32'h0);

    applyStimulus(32'h3007_0004, 1'b0, 32'h0, 32'hCAFE_0007, T - 1, 0);
    check32("late ack data", capturedDat, 32'hCAFE_0007);
    check32("late ack irq", 32'(irq), 32'h0);
    n = ackCount;
    applyStimulus(32'h3002_0000, 1'b0, 32'h0, 32'h0, -1, 2);
    check32("abort no ack", 32'(ackCount), 32'(n));
    applyStimulus(32'h3005_00AA, 1'b1, 32'hA5A5_5A5A, 32'h0, 0, 0);
    check32("write slave_dat", slvDat, 32'hA5A5_5A5A);
    check32("write slave_we", 32'(slvWe), 32'h1);

    resetMidActive();

    $display("[TB] random accesses");
    for (int k = 0; k < 250; k++) begin
      int r, nn, kd, ab;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: a = {8'h30, 8'($urandom_range(1, NT)), 16'($urandom)};
        4:          a = {16'h3100, 16'($urandom)};
        5:          a = {16'h3200, 16'($urandom)};
        6, 7:       a = {16'h3300, 16'($urandom)};
        8: begin
          nn = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(NT + 1, 255);
          a  = {8'h30, 8'(nn), 16'($urandom)};
        end
        default: a = ($urandom_range(0, 1) == 0) ? 32'($urandom)
                     : {8'h31, 8'($urandom_range(1, 255)), 16'($urandom)};
      endcase
      kd = $urandom_range(0, T + 1);
      if (kd >= T) kd = -1;
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, T - 1) : 0;
      applyStimulus(a, 1'($urandom_range(0, 1)), $urandom, $urandom, kd, ab);
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
    end

    $display("[TB] timeout count saturation");
    applyStimulus(32'h3300_0000, 1'b1, 32'h0, 32'h0, -1, 0);
    for (int k = 0; k < 258; k++) applyStimulus(32'h3100_0000, 1'b0, 32'h0, 32'h0, -1, 0);
    applyStimulus(32'h3300_0000, 1'b0, 32'h0, 32'h0, -1, 0);
    check32("saturated status", capturedDat, 32'h0001_FDFF);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
